data_ram_ctrl: RTL and testbench
================================

DATA_RAM_CTRL -- requirements
Module: data_ram_ctrl

Interface
REQ-001 Parameter NUM_WORDS, default 32, SHALL set the data RAM depth in 32-bit words.
REQ-002 Port clk_i  in  1  SHALL be the single clock, rising edge.
REQ-003 Port rst_ni  in  1  SHALL be the reset: asynchronous, active-low.
REQ-004 Ports req_i[1:0]  in  2  SHALL be the requests: port 0 is the core LSU, port 1 is debug/DMA.
REQ-005 Ports we_i[1:0], be_i[1:0][3:0], addr_i[1:0][31:0], wdata_i[1:0][31:0]  in  SHALL carry per-port write enable, byte enables, byte address and write data.
REQ-006 Ports gnt_o[1:0], rvalid_o[1:0], err_o[1:0]  out  1 each  SHALL signal grant, response valid and response error per port.
REQ-007 Port rdata_o  out  32  SHALL carry response read data, shared by both ports and qualified by rvalid_o.
REQ-008 RAM-side ports ce_o, wr_en_o (1), sel_o (4), addr_o (32), wdata_o (32)  out, and rdata_i (32)  in, SHALL drive the data RAM.
REQ-009 The data RAM has a combinational read and a full-word write, and writes on the clock edge when ce_o=1 and wr_en_o=1 and sel_o!=0.

Function
REQ-010 FSM states SHALL be IDLE and MERGE; state SHALL be IDLE after reset.
REQ-011 In IDLE, at most one gnt_o bit SHALL assert, combinationally, in the same cycle as its req_i; in MERGE, gnt_o SHALL be 0.
REQ-012 Arbitration SHALL be round-robin: on a conflict the port with priority wins; after any grant, priority SHALL pass to the other port; priority SHALL be port 0 after reset.
REQ-013 Read (we=0): in the grant cycle, drive ce_o=1, wr_en_o=0, addr_o; register rdata_i; assert rvalid_o for the granted port for exactly 1 cycle on the next cycle.
REQ-014 Full write (we=1, be=4'b1111): in the grant cycle, drive ce_o=1, wr_en_o=1, sel_o=4'b1111, wdata_o; assert rvalid_o on the next cycle.
REQ-015 Partial write (we=1, be not 0000 or 1111), grant cycle: drive a RAM read; capture addr, be and wdata together with a byte-wise merge of rdata_i (be lane from wdata, else from RAM); go to MERGE.
REQ-016 Partial write, MERGE cycle: drive ce_o=1, wr_en_o=1, sel_o=4'b1111 with the merged word; return to IDLE; assert rvalid_o on the next cycle.
REQ-017 Partial-write latency SHALL be 2 cycles from grant to rvalid_o; a new grant SHALL be possible in the cycle rvalid_o is asserted.
REQ-018 A write with be=4'b0000 SHALL be granted and acknowledged with rvalid_o next cycle, with no RAM write (wr_en_o=0).
REQ-019 If addr_i[31:2] >= NUM_WORDS, the request SHALL be granted without RAM access (ce_o=0), with rvalid_o and err_o both asserted next cycle and rdata_o=0.
REQ-020 addr_o SHALL be the word-aligned address, with bits [1:0] forced to 0.
REQ-021 When no RAM access occurs, ce_o, wr_en_o and sel_o SHALL be 0, and addr_o and wdata_o SHALL hold their last values.
REQ-022 rdata_o SHALL be 0 for write responses.
REQ-023 A requester SHALL hold req_i and its payload stable until gnt_o is seen; the block SHALL sample the payload only in the grant cycle.

Reset
REQ-024 Reset assertion SHALL immediately force: state IDLE, priority port 0, gnt_o=0, rvalid_o=0, err_o=0, rdata_o=0, ce_o=0, wr_en_o=0, sel_o=0, addr_o=0, wdata_o=0.
REQ-025 A partial write interrupted by reset while in MERGE SHALL be dropped: no RAM write and no response.

Structure
REQ-026 A shared package dram_pkg SHALL hold the FSM state enum, the request struct {we, be, addr, wdata} and the NUM_WORDS default.
REQ-027 Arbitration SHALL be a sub-module rr_arb2 (req[1:0], advance -> gnt[1:0]); merge and FSM logic SHALL stay in data_ram_ctrl.

Verification
REQ-028 Scenario: port 0 reads word 3 holding 0xDEADBEEF -> gnt_o[0] in the same cycle; rvalid_o[0]=1, rdata_o=0xDEADBEEF one cycle later.
REQ-029 Scenario: port 1 writes be=0110, data 0x11223344, to word 5 holding 0xAABBCCDD -> gnt, MERGE cycle writes 0xAA2233DD with sel_o=1111; rvalid_o[1] at grant+2.
REQ-030 Scenario: both ports request continuously from reset -> grants alternate 0,1,0,1; no port is starved.
REQ-031 Scenario: read at addr 0x80 with NUM_WORDS=32 -> ce_o stays 0; next cycle rvalid_o=1, err_o=1, rdata_o=0.
REQ-032 Scenario: rst_ni dropped during MERGE -> no RAM write; outputs at reset values; word unchanged on readback.
REQ-033 Scenario: write be=0000 to word 2 -> wr_en_o stays 0; rvalid_o next cycle; word 2 unchanged.

Source files
------------

// File: rtl/dram_pkg.sv
// rtl/dram_pkg.sv - shared types, defaults and byte-merge helper for the data RAM controller
package dram_pkg;

    localparam int unsigned DEF_NUM_WORDS = 32;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_MERGE = 1'b1
    } state_t;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    // Byte lanes with be set come from new_word, the rest keep the RAM contents
    function automatic logic [31:0] merge_bytes(input logic [31:0] ram_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        logic [31:0] merged;
        for (int b = 0; b < 4; b++) begin
            merged[8*b +: 8] = be[b] ? new_word[8*b +: 8] : ram_word[8*b +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-requester round-robin arbiter with combinational grant
module rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    // 0: port 0 wins a conflict, 1: port 1 wins a conflict
    logic r_prio;

    // Grant the single requester, or the priority holder on a conflict
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = r_prio ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

    // After any grant, priority moves to the port that was not served
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_prio <= 1'b0;
        end else if (advance) begin
            r_prio <= gnt[0];
        end
    end

endmodule

// File: rtl/data_ram_ctrl.sv
// rtl/data_ram_ctrl.sv - two-port data RAM controller with read-modify-write for partial stores
module data_ram_ctrl
    import dram_pkg::*;
#(
    parameter int unsigned NUM_WORDS = DEF_NUM_WORDS
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [1:0]      req_i,
    input  logic [1:0]      we_i,
    input  logic [1:0][3:0] be_i,
    input  logic [1:0][31:0] addr_i,
    input  logic [1:0][31:0] wdata_i,
    output logic [1:0]      gnt_o,
    output logic [1:0]      rvalid_o,
    output logic [1:0]      err_o,
    output logic [31:0]     rdata_o,
    output logic            ce_o,
    output logic            wr_en_o,
    output logic [3:0]      sel_o,
    output logic [31:0]     addr_o,
    output logic [31:0]     wdata_o,
    input  logic [31:0]     rdata_i
);

    state_t      r_state;
    state_t      w_state_nxt;

    logic [1:0]  w_arb_req;
    logic [1:0]  w_gnt;
    logic        w_any_gnt;
    logic        w_port;
    req_t        w_req;
    logic        w_oor;
    logic        w_full;
    logic        w_null;
    logic        w_part;

    logic [29:0] r_mrg_waddr;
    logic [31:0] r_mrg_wdata;
    logic        r_mrg_port;

    logic [31:0] r_addr_last;
    logic [31:0] r_wdata_last;
    logic [31:0] r_rdata;
    logic [1:0]  r_rvalid;
    logic [1:0]  r_err;

    logic        w_unused;

    // Requests are only arbitrated in IDLE and never while reset is held,
    // so a grant can't leak out combinationally during reset
    assign w_arb_req = (r_state == ST_IDLE && rst_ni) ? req_i : 2'b00;
    assign w_any_gnt = |w_gnt;
    assign w_port    = w_gnt[1];

    rr_arb2 u_arb (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .req     (w_arb_req),
        .advance (w_any_gnt),
        .gnt     (w_gnt)
    );

    // Payload of the granted port
    always_comb begin
        w_req       = '0;
        w_req.we    = we_i[w_port];
        w_req.be    = be_i[w_port];
        w_req.addr  = addr_i[w_port];
        w_req.wdata = wdata_i[w_port];
    end

    assign w_oor    = (w_req.addr[31:2] >= 30'(NUM_WORDS));
    assign w_full   = w_req.we && (w_req.be == 4'b1111);
    assign w_null   = w_req.we && (w_req.be == 4'b0000);
    assign w_part   = w_req.we && !w_full && !w_null;
    assign w_unused = ^w_req.addr[1:0];

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: only an in-range partial write needs the extra merge cycle
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_any_gnt && w_part && !w_oor) w_state_nxt = ST_MERGE;
            ST_MERGE: w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // RAM-side outputs; address and write data hold their last value when idle
    always_comb begin
        ce_o    = 1'b0;
        wr_en_o = 1'b0;
        sel_o   = 4'b0000;
        addr_o  = r_addr_last;
        wdata_o = r_wdata_last;
        case (r_state)
            ST_IDLE: begin
                if (w_any_gnt && !w_oor) begin
                    if (!w_req.we || w_part) begin
                        ce_o   = 1'b1;
                        addr_o = {w_req.addr[31:2], 2'b00};
                    end else if (w_full) begin
                        ce_o    = 1'b1;
                        wr_en_o = 1'b1;
                        sel_o   = 4'b1111;
                        addr_o  = {w_req.addr[31:2], 2'b00};
                        wdata_o = w_req.wdata;
                    end
                end
            end
            ST_MERGE: begin
                ce_o    = 1'b1;
                wr_en_o = 1'b1;
                sel_o   = 4'b1111;
                addr_o  = {r_mrg_waddr, 2'b00};
                wdata_o = r_mrg_wdata;
            end
            default: ;
        endcase
    end

    assign gnt_o    = w_gnt;
    assign rvalid_o = r_rvalid;
    assign err_o    = r_err;
    assign rdata_o  = r_rdata;

    // Remember the last driven RAM address and write data
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_addr_last  <= '0;
            r_wdata_last <= '0;
        end else begin
            r_addr_last  <= addr_o;
            r_wdata_last <= wdata_o;
        end
    end

    // Capture the merged word of a partial write during its grant cycle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_mrg_waddr <= '0;
            r_mrg_wdata <= '0;
            r_mrg_port  <= 1'b0;
        end else if (r_state == ST_IDLE && w_any_gnt && w_part && !w_oor) begin
            r_mrg_waddr <= w_req.addr[31:2];
            r_mrg_wdata <= merge_bytes(rdata_i, w_req.wdata, w_req.be);
            r_mrg_port  <= w_port;
        end
    end

    // One-cycle response: read data only for in-range reads, zero otherwise
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rvalid <= 2'b00;
            r_err    <= 2'b00;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= 2'b00;
            r_err    <= 2'b00;
            r_rdata  <= '0;
            if (r_state == ST_MERGE) begin
                r_rvalid[r_mrg_port] <= 1'b1;
            end else if (w_any_gnt && (w_oor || !w_part)) begin
                r_rvalid[w_port] <= 1'b1;
                r_err[w_port]    <= w_oor;
                if (!w_req.we && !w_oor) begin
                    r_rdata <= rdata_i;
                end
            end
        end
    end

endmodule

// File: tb/tb_data_ram_ctrl.sv
// tb/tb_data_ram_ctrl.sv - directed self-checking bench for data_ram_ctrl
module tb_data_ram_ctrl;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic [1:0]       req_i;
    logic [1:0]       we_i;
    logic [1:0][3:0]  be_i;
    logic [1:0][31:0] addr_i;
    logic [1:0][31:0] wdata_i;
    logic [1:0]       gnt_o;
    logic [1:0]       rvalid_o;
    logic [1:0]       err_o;
    logic [31:0]      rdata_o;
    logic             ce_o;
    logic             wr_en_o;
    logic [3:0]       sel_o;
    logic [31:0]      addr_o;
    logic [31:0]      wdata_o;
    logic [31:0]      rdata_i;

    logic [31:0]      mem [32];
    logic             pl_en;
    logic [4:0]       pl_idx;
    logic [31:0]      pl_data;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk_i = ~clk_i;

    data_ram_ctrl #(.NUM_WORDS(32)) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .req_i    (req_i),
        .we_i     (we_i),
        .be_i     (be_i),
        .addr_i   (addr_i),
        .wdata_i  (wdata_i),
        .gnt_o    (gnt_o),
        .rvalid_o (rvalid_o),
        .err_o    (err_o),
        .rdata_o  (rdata_o),
        .ce_o     (ce_o),
        .wr_en_o  (wr_en_o),
        .sel_o    (sel_o),
        .addr_o   (addr_o),
        .wdata_o  (wdata_o),
        .rdata_i  (rdata_i)
    );

    // RAM model: combinational read, byte-lane write on the clock edge
    assign rdata_i = mem[addr_o[6:2]];

    always @(posedge clk_i) begin
        if (pl_en) begin
            mem[pl_idx] <= pl_data;
        end else if (ce_o && wr_en_o) begin
            for (int b = 0; b < 4; b++) begin
                if (sel_o[b]) mem[addr_o[6:2]][8*b +: 8] <= wdata_o[8*b +: 8];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic preload(input logic [4:0] idx, input logic [31:0] data);
        pl_en   = 1'b1;
        pl_idx  = idx;
        pl_data = data;
        tick();
        pl_en   = 1'b0;
    endtask

    task automatic set_req(input int p, input logic we, input logic [3:0] be,
                           input logic [31:0] addr, input logic [31:0] wdata);
        req_i[p]   = 1'b1;
        we_i[p]    = we;
        be_i[p]    = be;
        addr_i[p]  = addr;
        wdata_i[p] = wdata;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst_ni  = 1'b0;
        req_i   = '0;
        we_i    = '0;
        be_i    = '0;
        addr_i  = '0;
        wdata_i = '0;
        pl_en   = 1'b0;
        pl_idx  = '0;
        pl_data = '0;
        #1;
        for (int i = 0; i < 32; i++) preload(5'(i), 32'h0);
        preload(5'd2, 32'h12345678);
        preload(5'd3, 32'hDEADBEEF);
        preload(5'd4, 32'h01020304);
        preload(5'd5, 32'hAABBCCDD);

        // Reset holds everything quiet even with requests pending
        set_req(0, 1'b1, 4'b1111, 32'h0000_000C, 32'hFFFF_FFFF);
        set_req(1, 1'b0, 4'b0000, 32'h0000_0014, 32'h0);
        #2;
        chk("rst_gnt", gnt_o, 2'b00);
        chk("rst_ce", ce_o, 1'b0);
        chk("rst_wr", wr_en_o, 1'b0);
        chk("rst_sel", sel_o, 4'b0000);
        chk("rst_addr", addr_o, 32'h0);
        chk("rst_wdata", wdata_o, 32'h0);
        chk("rst_rvalid", rvalid_o, 2'b00);
        chk("rst_err", err_o, 2'b00);
        chk("rst_rdata", rdata_o, 32'h0);
        tick();
        rst_ni = 1'b1;

        // Both ports read continuously: grants alternate starting with port 0
        set_req(0, 1'b0, 4'b0000, 32'h0000_000C, 32'h0);
        set_req(1, 1'b0, 4'b0000, 32'h0000_0014, 32'h0);
        for (int k = 0; k < 4; k++) begin
            #2;
            chk("rr_gnt", gnt_o, (k % 2 == 0) ? 2'b01 : 2'b10);
            tick();
            chk("rr_rvalid", rvalid_o, (k % 2 == 0) ? 2'b01 : 2'b10);
            chk("rr_rdata", rdata_o, (k % 2 == 0) ? 32'hDEADBEEF : 32'hAABBCCDD);
        end
        req_i = 2'b00;
        tick();

        // Port 0 reads word 3
        set_req(0, 1'b0, 4'b0000, 32'h0000_000C, 32'h0);
        #2;
        chk("rd_gnt", gnt_o, 2'b01);
        chk("rd_ce", ce_o, 1'b1);
        chk("rd_wr", wr_en_o, 1'b0);
        chk("rd_addr", addr_o, 32'h0000_000C);
        tick();
        req_i = 2'b00;
        #1;
        chk("rd_rvalid", rvalid_o, 2'b01);
        chk("rd_rdata", rdata_o, 32'hDEADBEEF);
        chk("rd_err", err_o, 2'b00);
        tick();
        chk("rd_rvalid_once", rvalid_o, 2'b00);
        chk("rd_idle_ce", ce_o, 1'b0);

        // Port 1 partial write be=0110 into word 5
        set_req(1, 1'b1, 4'b0110, 32'h0000_0014, 32'h11223344);
        #2;
        chk("pw_gnt", gnt_o, 2'b10);
        chk("pw_ce", ce_o, 1'b1);
        chk("pw_wr", wr_en_o, 1'b0);
        chk("pw_addr", addr_o, 32'h0000_0014);
        tick();
        req_i = 2'b00;
        set_req(0, 1'b0, 4'b0000, 32'h0000_0014, 32'h0);
        #1;
        chk("mg_gnt", gnt_o, 2'b00);
        chk("mg_ce", ce_o, 1'b1);
        chk("mg_wr", wr_en_o, 1'b1);
        chk("mg_sel", sel_o, 4'b1111);
        chk("mg_addr", addr_o, 32'h0000_0014);
        chk("mg_wdata", wdata_o, 32'hAA2233DD);
        chk("mg_rvalid", rvalid_o, 2'b00);
        tick();
        chk("pw_rvalid", rvalid_o, 2'b10);
        chk("pw_rdata", rdata_o, 32'h0);
        chk("pw_next_gnt", gnt_o, 2'b01);
        chk("pw_mem5", mem[5], 32'hAA2233DD);
        tick();
        req_i = 2'b00;
        #1;
        chk("pw_rb_rvalid", rvalid_o, 2'b01);
        chk("pw_rb_rdata", rdata_o, 32'hAA2233DD);
        tick();

        // Out-of-range read at 0x80
        set_req(0, 1'b0, 4'b0000, 32'h0000_0080, 32'h0);
        #2;
        chk("oor_gnt", gnt_o, 2'b01);
        chk("oor_ce", ce_o, 1'b0);
        chk("oor_addr_hold", addr_o, 32'h0000_0014);
        tick();
        req_i = 2'b00;
        #1;
        chk("oor_rvalid", rvalid_o, 2'b01);
        chk("oor_err", err_o, 2'b01);
        chk("oor_rdata", rdata_o, 32'h0);
        tick();

        // Null write be=0000 to word 2
        set_req(1, 1'b1, 4'b0000, 32'h0000_0008, 32'hFFFF_FFFF);
        #2;
        chk("nw_gnt", gnt_o, 2'b10);
        chk("nw_ce", ce_o, 1'b0);
        chk("nw_wr", wr_en_o, 1'b0);
        tick();
        req_i = 2'b00;
        #1;
        chk("nw_rvalid", rvalid_o, 2'b10);
        chk("nw_err", err_o, 2'b00);
        chk("nw_mem2", mem[2], 32'h12345678);
        tick();

        // Full write to word 7
        set_req(0, 1'b1, 4'b1111, 32'h0000_001C, 32'hCAFEF00D);
        #2;
        chk("fw_gnt", gnt_o, 2'b01);
        chk("fw_ce", ce_o, 1'b1);
        chk("fw_wr", wr_en_o, 1'b1);
        chk("fw_sel", sel_o, 4'b1111);
        chk("fw_wdata", wdata_o, 32'hCAFEF00D);
        tick();
        req_i = 2'b00;
        #1;
        chk("fw_rvalid", rvalid_o, 2'b01);
        chk("fw_rdata", rdata_o, 32'h0);
        chk("fw_mem7", mem[7], 32'hCAFEF00D);
        tick();

        // Partial write to word 4 interrupted by reset during MERGE
        set_req(1, 1'b1, 4'b0001, 32'h0000_0010, 32'hFFFF_FFEE);
        #2;
        chk("rm_gnt", gnt_o, 2'b10);
        tick();
        req_i = 2'b00;
        #1;
        chk("rm_merge_wr", wr_en_o, 1'b1);
        #1;
        rst_ni = 1'b0;
        #1;
        chk("rm_ce", ce_o, 1'b0);
        chk("rm_wr", wr_en_o, 1'b0);
        chk("rm_sel", sel_o, 4'b0000);
        chk("rm_addr", addr_o, 32'h0);
        chk("rm_wdata", wdata_o, 32'h0);
        tick();
        chk("rm_mem4", mem[4], 32'h01020304);
        chk("rm_rvalid", rvalid_o, 2'b00);
        rst_ni = 1'b1;
        tick();
        chk("rm_no_resp", rvalid_o, 2'b00);
        set_req(0, 1'b0, 4'b0000, 32'h0000_0010, 32'h0);
        #2;
        chk("rm_rb_gnt", gnt_o, 2'b01);
        tick();
        req_i = 2'b00;
        #1;
        chk("rm_rb_rdata", rdata_o, 32'h01020304);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
